dram_rd_streamer: RTL and testbench

DRAM_RD_STREAMER -- requirements
Module: dram_rd_streamer

---
 rtl/dram_rd_streamer_if.sv | 47 ++++
 rtl/dram_rd_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_dram_rd_streamer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_rd_streamer_if.sv
// dram_rd_streamer_if
//   Groups the control, DRAM read and output stream signals of the
//   DRAM read streamer into one bundle.
//   master : streamer side (drives status, DRAM requests, output stream)
//   slave  : environment side (drives start/operands, DRAM returns, out_ready)
//
//   start / base_addr / len       transfer request and operands
//   busy / done                   transfer status
//   dram_en_rd / dram_addr_rd     DRAM read request
//   dram_valid / dram_data_rd     DRAM read return (in request order)
//   out_valid / out_data / out_ready   word stream to the compute engine
interface dram_rd_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  busy;
    logic                  done;
    logic                  dram_en_rd;
    logic [ADDR_WIDTH-1:0] dram_addr_rd;
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] dram_data_rd;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  start, base_addr, len,
        output busy, done,
        output dram_en_rd, dram_addr_rd,
        input  dram_valid, dram_data_rd,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        output start, base_addr, len,
        input  busy, done,
        input  dram_en_rd, dram_addr_rd,
        output dram_valid, dram_data_rd,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/dram_rd_streamer.sv
// dram_rd_streamer
//   Reads len consecutive words from DRAM starting at base_addr and streams
//   them, in address order, to a compute engine through a small
//   first-word-fall-through buffer. Read requests are throttled by a credit
//   count (requests in flight + words buffered) so the buffer can never
//   overflow, whatever the DRAM latency.
//
//   clk    : clock, all state updates on the rising edge
//   srstn  : synchronous reset, active low
//   bus    : dram_rd_streamer_if.master (request, status, DRAM read port,
//            output stream)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; stray DRAM returns are dropped
//   ISSUE  | issuing reads while credit allows; output stream active
//   DRAIN  | all reads issued; waiting for the last word to be popped
//   DONE   | one-cycle done pulse, back to IDLE
module dram_rd_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 srstn,
    dram_rd_streamer_if.master   bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [LEN_WIDTH-1:0]  popped_q;
    logic [CNT_W-1:0]      outstanding_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  active;
    logic                  fifo_nempty;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  last_pop;
    logic                  accept_start;
    logic [CNT_W:0]        credit;

    // ------------------------------------------------------------------
    // Shared datapath conditions
    // ------------------------------------------------------------------
    always_comb begin
        active       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        fifo_nempty  = (count_q != '0);
        pop          = fifo_nempty && bus.out_ready;
        // A return is only taken while a request is actually outstanding;
        // this also drops leftovers from a transfer abandoned by reset.
        push         = active && bus.dram_valid && (outstanding_q != '0);
        accept_start = (state_q == S_IDLE) && bus.start;

        // A pop this cycle frees its slot before the new request's data can
        // arrive (latency >= 1), so it counts towards credit immediately.
        // This is what lets latency FIFO_DEPTH-1 still run at full rate.
        credit = (CNT_W+1)'(outstanding_q) + (CNT_W+1)'(count_q)
               - (CNT_W+1)'(pop);

        issue      = (state_q == S_ISSUE) && (issued_q != len_q)
                     && (credit < (CNT_W+1)'(FIFO_DEPTH));
        last_issue = issue && ((issued_q + LEN_WIDTH'(1)) == len_q);
        last_pop   = pop && ((popped_q + LEN_WIDTH'(1)) == len_q);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy         = active;
        bus.done         = (state_q == S_DONE);
        bus.dram_en_rd   = issue;
        bus.dram_addr_rd = '0;
        if (issue) begin
            // Wraps modulo 2^ADDR_WIDTH by construction.
            bus.dram_addr_rd = base_q + ADDR_WIDTH'(issued_q);
        end
        bus.out_valid = fifo_nempty;
        bus.out_data  = fifo_nempty ? mem[rd_ptr_q] : '0;
    end

    // ------------------------------------------------------------------
    // Transfer operands and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!srstn) begin
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
        end else if (accept_start) begin
            base_q        <= bus.base_addr;
            len_q         <= bus.len;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
        end else begin
            if (issue) begin
                issued_q <= issued_q + LEN_WIDTH'(1);
            end
            if (pop) begin
                popped_q <= popped_q + LEN_WIDTH'(1);
            end
            if (issue && !push) begin
                outstanding_q <= outstanding_q + CNT_W'(1);
            end else if (!issue && push) begin
                outstanding_q <= outstanding_q - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Data buffer pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!srstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: out_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.dram_data_rd;
        end
    end

endmodule

// File: tb/tb_dram_rd_streamer.sv
// Directed testbench for dram_rd_streamer with an in-order DRAM responder
// of programmable latency.
module tb_dram_rd_streamer;

    logic clk = 1'b0;
    logic srstn;

    always #5 clk = ~clk;

    dram_rd_streamer_if bus ();

    dram_rd_streamer dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    int n_iss, n_pop, n_done, first_iss, last_iss, done_cyc, saw_valid;

    // DRAM responder: request seen in cycle t returns in cycle t+lat.
    int        lat = 1;
    bit        vpipe [8];
    bit [31:0] dpipe [8];

    function automatic logic [31:0] data_of(input logic [17:0] a);
        return 32'hA500_0000 ^ {14'h0, a};
    endfunction

    always @(negedge clk) begin
        bus.dram_valid   = vpipe[lat-1];
        bus.dram_data_rd = dpipe[lat-1];
        for (int i = 7; i > 0; i--) begin
            vpipe[i] = vpipe[i-1];
            dpipe[i] = dpipe[i-1];
        end
        vpipe[0] = bus.dram_en_rd;
        dpipe[0] = data_of(bus.dram_addr_rd);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer from the drive point. Cycle c=0 is the start cycle.
    task automatic stream(input logic [17:0] b, input logic [15:0] n,
                          input int hold, input int exp_hold_iss,
                          input int restart_c, input int budget);
        logic [17:0] ea;
        n_iss = 0; n_pop = 0; n_done = 0; first_iss = -1; last_iss = -1;
        done_cyc = -1; saw_valid = 0;
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.len       = n;
        bus.out_ready = (hold == 0);
        for (int c = 0; c < budget && n_done == 0; c++) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1;
            if (bus.dram_en_rd) begin
                ea = b + 18'(n_iss);
                check("iss_addr", bus.dram_addr_rd, ea);
                if (first_iss < 0) first_iss = c;
                last_iss = c;
                n_iss++;
            end
            if (bus.out_valid && bus.out_ready) begin
                ea = b + 18'(n_pop);
                check("out_data", bus.out_data, data_of(ea));
                n_pop++;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = c;
            end
            if (hold > 0 && c == hold - 1) begin
                check("hold_issued", n_iss, exp_hold_iss);
                check("hold_en_rd", bus.dram_en_rd, 0);
                check("hold_head", bus.out_data, data_of(b));
            end
            to_drive();
            bus.start = (c + 1 == restart_c);
            if (c + 1 == restart_c) begin
                bus.base_addr = 18'h3000;
                bus.len       = 16'd7;
            end
            bus.out_ready = (c + 1 >= hold);
        end
        check("done_seen", n_done, 1);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("busy_after", bus.busy, 0);
        check("issued_total", n_iss, n);
        check("popped_total", n_pop, n);
    endtask

    initial begin
        int pops;
        int any_valid;
        srstn         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_en_rd", bus.dram_en_rd, 0);
        check("rst_addr", bus.dram_addr_rd, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        srstn = 1'b1;
        to_drive();

        // base 0x100, len 4, latency 1: back-to-back issue, done at c=7
        lat = 1;
        stream(18'h100, 16'd4, 0, 0, -1, 40);
        check("a_first_iss", first_iss, 1);
        check("a_last_iss", last_iss, 4);
        check("a_done_cyc", done_cyc, 7);

        // len 0: no reads, done one cycle after start, nothing streamed
        to_drive();
        stream(18'h55, 16'd0, 0, 0, -1, 10);
        check("z_done_cyc", done_cyc, 1);
        check("z_no_valid", saw_valid, 0);

        // len 20 with consumer stalled 30 cycles: credit caps reads at 8
        to_drive();
        lat = 2;
        stream(18'h1000, 16'd20, 30, 8, -1, 120);

        // address wrap at 2^18
        to_drive();
        stream(18'h3FFFE, 16'd4, 0, 0, -1, 40);

        // full rate at latency 4: 12 consecutive issues, done at c=18
        to_drive();
        lat = 4;
        stream(18'h2000, 16'd12, 0, 0, -1, 60);
        check("t_iss_span", last_iss - first_iss, 11);
        check("t_done_cyc", done_cyc, 18);

        // start while busy is ignored; original transfer completes
        to_drive();
        lat = 3;
        stream(18'h500, 16'd6, 0, 0, 2, 60);

        // reset after 3 of 10 words popped, then a fresh transfer
        to_drive();
        pops          = 0;
        bus.start     = 1'b1;
        bus.base_addr = 18'h200;
        bus.len       = 16'd10;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60 && pops < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                check("r_out_data", bus.out_data, data_of(18'h200 + 18'(pops)));
                pops++;
            end
            to_drive();
            bus.start = 1'b0;
        end
        check("r_pops", pops, 3);
        bus.out_ready = 1'b0;
        srstn         = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("r_busy", bus.busy, 0);
        check("r_out_valid", bus.out_valid, 0);
        srstn     = 1'b1;
        any_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) any_valid = 1;
        end
        check("r_stale_dropped", any_valid, 0);
        to_drive();
        stream(18'h40, 16'd2, 0, 0, -1, 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
